// File: rtl/ex_muldiv_unit.sv
// Iterative 16-bit unsigned multiply/divide for the EX stage: shift-add multiply,
// restoring divide, 16 iterations, stalls ID/EX until a one-cycle result pulse.
module ex_muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [1:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [2:0]  rd_in,
    input  logic        reg_write_in,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        result_valid,
    output logic [15:0] result,
    output logic [2:0]  rd_out,
    output logic        reg_write_out,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  count;
    logic [31:0] acc, acc_nxt;
    logic [15:0] opnd;
    logic [1:0]  op_q;
    logic [2:0]  rd_q;
    logic        reg_write_q;
    logic        start, finish;

    // acc = {partial product high, multiplier being shifted out}
    function automatic logic [31:0] mul_step(input logic [31:0] w, input logic [15:0] m);
        logic [16:0] sum;
        sum = {1'b0, w[31:16]} + (w[0] ? {1'b0, m} : 17'd0);
        return {sum, w[15:1]};
    endfunction

    // acc = {remainder, dividend bits shifting out / quotient bits shifting in}
    function automatic logic [31:0] div_step(input logic [31:0] w, input logic [15:0] d);
        logic [16:0] sh;
        logic [15:0] diff;
        logic        ge;
        sh   = {w[31:16], w[15]};
        ge   = (sh >= {1'b0, d});
        diff = sh[15:0] - d;
        return {(ge ? diff : sh[15:0]), w[14:0], ge};
    endfunction

    function automatic logic [15:0] sel_result(input logic [1:0] o, input logic [31:0] w);
        return o[0] ? w[31:16] : w[15:0];
    endfunction

    assign acc_nxt = op_q[1] ? div_step(acc, opnd) : mul_step(acc, opnd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        start     = 1'b0;
        finish    = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (op_valid && !flush) begin
                    stall     = 1'b1;
                    start     = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else begin
                    stall = 1'b1;
                    if (count == 4'd15) begin
                        finish    = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count         <= 4'd0;
            result_valid  <= 1'b0;
            reg_write_out <= 1'b0;
            result        <= 16'h0000;
            rd_out        <= 3'd0;
            div_by_zero   <= 1'b0;
        end else begin
            if (start) begin
                count <= 4'd0;
            end else if (state == BUSY) begin
                count <= count + 4'd1;
            end
            result_valid  <= finish;
            reg_write_out <= finish & reg_write_q;
            if (finish) begin
                result      <= sel_result(op_q, acc_nxt);
                rd_out      <= rd_q;
                div_by_zero <= op_q[1] && (opnd == 16'h0000);
            end
        end
    end

    // operand capture and iteration datapath; meaningful only while BUSY
    always_ff @(posedge clk) begin
        if (start) begin
            op_q        <= op;
            rd_q        <= rd_in;
            reg_write_q <= reg_write_in;
            opnd        <= op[1] ? b : a;
            acc         <= {16'h0000, (op[1] ? a : b)};
        end else if (state == BUSY) begin
            acc <= acc_nxt;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed and random mul/div operations checked
// against an arithmetic reference, plus reset, flush and back-to-back timing.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [15:0] a = 16'h0;
    logic [15:0] b = 16'h0;
    logic [2:0]  rd_in = 3'd0;
    logic        reg_write_in = 1'b0;
    logic        flush = 1'b0;
    logic        stall, busy, result_valid;
    logic [15:0] result;
    logic [2:0]  rd_out;
    logic        reg_write_out, div_by_zero;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] last_exp = 16'h0;
    logic        last_dbz = 1'b0;

    ex_muldiv_unit dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .a(a), .b(b),
        .rd_in(rd_in), .reg_write_in(reg_write_in), .flush(flush),
        .stall(stall), .busy(busy), .result_valid(result_valid), .result(result),
        .rd_out(rd_out), .reg_write_out(reg_write_out), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] ref_result(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
        logic [31:0] p;
        p = 32'(x) * 32'(y);
        case (o)
            2'd0:    return p[15:0];
            2'd1:    return p[31:16];
            2'd2:    return (y == 16'h0) ? 16'hFFFF : x / y;
            default: return (y == 16'h0) ? x : x % y;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                            input logic [2:0] rd, input logic rw);
        @(posedge clk); #1;
        op_valid = 1'b1; op = o; a = x; b = y; rd_in = rd; reg_write_in = rw;
        #1;
    endtask

    task automatic do_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                         input logic [2:0] rd, input logic rw);
        int nst, nrv;
        logic [15:0] exp;
        logic        dbz;
        exp = ref_result(o, x, y);
        dbz = o[1] && (y == 16'h0);
        start_op(o, x, y, rd, rw);
        chk("c0_stall", 32'(stall), 1);
        chk("c0_valid", 32'(result_valid), 0);
        nst = 0;
        nrv = 0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            nst += int'(stall);
            nrv += int'(result_valid);
        end
        chk("busy_stall_cycles", nst, 16);
        chk("busy_valid_cycles", nrv, 0);
        @(posedge clk); #1;
        chk("c17_valid", 32'(result_valid), 1);
        chk("c17_result", 32'(result), 32'(exp));
        chk("c17_stall", 32'(stall), 0);
        chk("c17_rd_out", 32'(rd_out), 32'(rd));
        chk("c17_reg_write", 32'(reg_write_out), 32'(rw));
        chk("c17_div_by_zero", 32'(div_by_zero), 32'(dbz));
        last_exp = exp;
        last_dbz = dbz;
    endtask

    task automatic idle_step();
        @(posedge clk); #1;
        op_valid = 1'b0;
        #1;
        chk("post_valid", 32'(result_valid), 0);
        chk("post_reg_write", 32'(reg_write_out), 0);
        chk("post_stall", 32'(stall), 0);
        chk("post_busy", 32'(busy), 0);
        chk("post_result_hold", 32'(result), 32'(last_exp));
        chk("post_dbz_hold", 32'(div_by_zero), 32'(last_dbz));
    endtask

    initial begin
        int nrv;
        logic [1:0]  ro;
        logic [15:0] rx, ry;

        // reset values
        #1 rst = 1'b1;
        #2;
        chk("rst_result", 32'(result), 0);
        chk("rst_valid", 32'(result_valid), 0);
        chk("rst_rd_out", 32'(rd_out), 0);
        chk("rst_reg_write", 32'(reg_write_out), 0);
        chk("rst_dbz", 32'(div_by_zero), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_stall", 32'(stall), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // directed operations
        do_op(2'd0, 16'h1234, 16'h0010, 3'd1, 1'b1);
        idle_step();
        do_op(2'd1, 16'hFFFF, 16'hFFFF, 3'd2, 1'b1);
        idle_step();
        do_op(2'd0, 16'hFFFF, 16'hFFFF, 3'd3, 1'b0);
        idle_step();
        do_op(2'd2, 16'd100, 16'd7, 3'd5, 1'b1);
        idle_step();
        do_op(2'd3, 16'd100, 16'd7, 3'd5, 1'b1);
        idle_step();
        do_op(2'd2, 16'h1234, 16'h0000, 3'd4, 1'b1);
        idle_step();
        do_op(2'd3, 16'h1234, 16'h0000, 3'd6, 1'b1);
        idle_step();

        // back-to-back with op_valid held high
        do_op(2'd0, 16'd3, 16'd5, 3'd1, 1'b1);
        do_op(2'd2, 16'd15, 16'd4, 3'd2, 1'b1);
        idle_step();

        // random operations, some back-to-back
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = 16'($urandom);
            case ($urandom_range(0, 7))
                0:       ry = 16'h0000;
                1:       ry = 16'($urandom_range(1, 15));
                default: ry = 16'($urandom);
            endcase
            do_op(ro, rx, ry, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_step();
        end
        idle_step();

        // reset in the middle of an operation
        start_op(2'd0, 16'hABCD, 16'h1234, 3'd6, 1'b1);
        for (int k = 1; k <= 8; k++) @(posedge clk);
        #1;
        rst = 1'b1;
        op_valid = 1'b0;
        #1;
        chk("midrst_result", 32'(result), 0);
        chk("midrst_valid", 32'(result_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_stall", 32'(stall), 0);
        chk("midrst_rd_out", 32'(rd_out), 0);
        chk("midrst_dbz", 32'(div_by_zero), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        nrv = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            nrv += int'(result_valid);
        end
        chk("midrst_no_pulse", nrv, 0);

        // flush while busy
        start_op(2'd2, 16'd1000, 16'd3, 3'd2, 1'b1);
        for (int k = 1; k <= 5; k++) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        chk("flush_stall", 32'(stall), 0);
        @(posedge clk); #1;
        flush = 1'b0;
        op_valid = 1'b0;
        #1;
        chk("flush_busy", 32'(busy), 0);
        nrv = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            nrv += int'(result_valid);
        end
        chk("flush_no_pulse", nrv, 0);

        // flush while idle with op_valid
        @(posedge clk); #1;
        op_valid = 1'b1;
        flush = 1'b1;
        #1;
        chk("flush_idle_stall", 32'(stall), 0);
        @(posedge clk); #1;
        chk("flush_idle_busy", 32'(busy), 0);
        op_valid = 1'b0;
        flush = 1'b0;

        // recovery after flush
        do_op(2'd0, 16'd7, 16'd9, 3'd7, 1'b1);
        idle_step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
